prince_sbox_layer_seq: RTL and testbench

- Nibble-serial sequencer for one masked inverse S-box layer of a 3-share (2nd-order) PRINCE datapath.
- Sits directly upstream of the pipelined masked inverse S-box: takes a full 3-share 64-bit state and streams its 16 nibbles into the S-box, one per cycle.
- Supplies the S-box with fresh randomness and routes its `klmn` recycling bits.
- Collects the pipelined outputs back into a 3-share 64-bit result and pulses `done_o`.

---
 rtl/prince_sbox_layer_seq.sv | 193 +++++++++++++++++++
 tb/tb_prince_sbox_layer_seq.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_sbox_layer_seq.sv
// Nibble-serial sequencer feeding a 3-share masked PRINCE inverse S-box.
// Optional PRINCE_SEQ_ZERO_IDLE_EN zeroes the S-box inputs outside FEED.

module prince_sbox_layer_seq #(
  parameter int SBOX_LAT = 4,
  parameter int NNIB     = 16
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] state_in1,
  input  logic [63:0] state_in2,
  input  logic [63:0] state_in3,
  input  logic [46:0] rnd_i,
  output logic [3:0]  sbox_in1,
  output logic [3:0]  sbox_in2,
  output logic [3:0]  sbox_in3,
  output logic [42:0] sbox_r_o,
  output logic [3:0]  sbox_klmn1_o,
  output logic [5:0]  sbox_klmn2_o,
  input  logic [5:0]  sbox_klmn_out_i,
  input  logic [3:0]  sbox_out1,
  input  logic [3:0]  sbox_out2,
  input  logic [3:0]  sbox_out3,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] state_out1,
  output logic [63:0] state_out2,
  output logic [63:0] state_out3
);

  localparam logic [3:0] LAST = 4'(NNIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_rd_cnt;
  logic [3:0]  r_wr_cnt;
  logic [SBOX_LAT:0] r_vld;
  logic [63:0] r_sh1, r_sh2, r_sh3;
  logic [63:0] r_acc1, r_acc2, r_acc3;
  logic [63:0] r_out1, r_out2, r_out3;
  logic [3:0]  r_in1, r_in2, r_in3;
  logic [42:0] r_r;
  logic [3:0]  r_k1;
  logic [5:0]  r_k2;

  logic        w_start;
  logic        w_issue;
  logic        w_cap;
  logic        w_to_done;
  logic [5:0]  w_pos;
  logic [3:0]  w_nib1, w_nib2, w_nib3;
  logic [63:0] w_acc1, w_acc2, w_acc3;

  assign w_start   = (r_state == S_IDLE) && start_i;
  assign w_issue   = w_start ||
                     ((r_state == S_FEED) && (r_rd_cnt != LAST));
  assign w_cap     = r_vld[SBOX_LAT];
  assign w_to_done = (r_state == S_DRAIN) && (w_next == S_DONE);
  assign w_pos     = {r_wr_cnt, 2'b00};

  // Nibble 0 goes out on the accepting edge, later ones from the shifters
  assign w_nib1 = w_start ? state_in1[3:0] : r_sh1[3:0];
  assign w_nib2 = w_start ? state_in2[3:0] : r_sh2[3:0];
  assign w_nib3 = w_start ? state_in3[3:0] : r_sh3[3:0];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_FEED;
      S_FEED:  if (r_rd_cnt == LAST) w_next = S_DRAIN;
      S_DRAIN: if (r_vld[SBOX_LAT-1:0] == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != S_IDLE);
    done_o = (r_state == S_DONE);
  end

  assign sbox_in1     = r_in1;
  assign sbox_in2     = r_in2;
  assign sbox_in3     = r_in3;
  assign sbox_r_o     = r_r;
  assign sbox_klmn1_o = r_k1;
  assign sbox_klmn2_o = r_k2;
  assign state_out1   = r_out1;
  assign state_out2   = r_out2;
  assign state_out3   = r_out3;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_vld    <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_sh1    <= '0;
      r_sh2    <= '0;
      r_sh3    <= '0;
    end else begin
      r_vld <= {r_vld[SBOX_LAT-1:0], w_issue};
      if (w_start) begin
        r_sh1    <= state_in1 >> 4;
        r_sh2    <= state_in2 >> 4;
        r_sh3    <= state_in3 >> 4;
        r_rd_cnt <= '0;
      end else if (r_state == S_FEED) begin
        r_sh1    <= r_sh1 >> 4;
        r_sh2    <= r_sh2 >> 4;
        r_sh3    <= r_sh3 >> 4;
        r_rd_cnt <= r_rd_cnt + 4'd1;
      end
      if (w_start)    r_wr_cnt <= '0;
      else if (w_cap) r_wr_cnt <= r_wr_cnt + 4'd1;
    end
  end

  // Last capture and result publish share an edge, so publish the merged view
  always_comb begin
    w_acc1 = r_acc1;
    w_acc2 = r_acc2;
    w_acc3 = r_acc3;
    if (w_cap) begin
      w_acc1[w_pos +: 4] = sbox_out1;
      w_acc2[w_pos +: 4] = sbox_out2;
      w_acc3[w_pos +: 4] = sbox_out3;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
      r_out1 <= '0;
      r_out2 <= '0;
      r_out3 <= '0;
    end else begin
      r_acc1 <= w_acc1;
      r_acc2 <= w_acc2;
      r_acc3 <= w_acc3;
      if (w_to_done) begin
        r_out1 <= w_acc1;
        r_out2 <= w_acc2;
        r_out3 <= w_acc3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_in3 <= '0;
      r_r   <= '0;
      r_k1  <= '0;
      r_k2  <= '0;
    end else if (w_issue) begin
      r_in1 <= w_nib1;
      r_in2 <= w_nib2;
      r_in3 <= w_nib3;
      r_r   <= rnd_i[42:0];
      r_k1  <= rnd_i[46:43];
      r_k2  <= sbox_klmn_out_i;
    end
`ifdef PRINCE_SEQ_ZERO_IDLE_EN
    else begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_in3 <= '0;
      r_r   <= '0;
      r_k1  <= '0;
      r_k2  <= '0;
    end
`else
`endif
  end

endmodule

// File: tb/tb_prince_sbox_layer_seq.sv
// Bench for prince_sbox_layer_seq with a behavioural 4-cycle masked S-box.
// Expected results come from per-nibble PRINCE inverse S-box arithmetic.

module tb_prince_sbox_layer_seq;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [63:0] state_in1, state_in2, state_in3;
  logic [46:0] rnd_i;
  logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
  logic [42:0] sbox_r_o;
  logic [3:0]  sbox_klmn1_o;
  logic [5:0]  sbox_klmn2_o;
  logic [5:0]  sbox_klmn_out_i;
  logic [3:0]  sbox_out1, sbox_out2, sbox_out3;
  logic        busy_o, done_o;
  logic [63:0] state_out1, state_out2, state_out3;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  prince_sbox_layer_seq #(.SBOX_LAT(LAT), .NNIB(16)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i),
    .state_in1(state_in1), .state_in2(state_in2),
    .state_in3(state_in3), .rnd_i(rnd_i),
    .sbox_in1(sbox_in1), .sbox_in2(sbox_in2),
    .sbox_in3(sbox_in3), .sbox_r_o(sbox_r_o),
    .sbox_klmn1_o(sbox_klmn1_o), .sbox_klmn2_o(sbox_klmn2_o),
    .sbox_klmn_out_i(sbox_klmn_out_i),
    .sbox_out1(sbox_out1), .sbox_out2(sbox_out2),
    .sbox_out3(sbox_out3), .busy_o(busy_o), .done_o(done_o),
    .state_out1(state_out1), .state_out2(state_out2),
    .state_out3(state_out3)
  );

  logic [3:0] SINV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD,
                            4'h8, 4'h9, 4'hA, 4'h6, 4'h4, 4'h0,
                            4'h5, 4'hE, 4'hC, 4'h1};

  // Stand-in masked S-box: share-specific refresh so routing errors show
  logic [3:0] c1, c2, c3;
  logic [3:0] p1 [LAT];
  logic [3:0] p2 [LAT];
  logic [3:0] p3 [LAT];

  always_comb begin
    c2 = {sbox_in2[2:0], sbox_in2[3]} ^ sbox_r_o[3:0];
    c3 = sbox_in3 ^ sbox_klmn1_o;
    c1 = SINV[sbox_in1 ^ sbox_in2 ^ sbox_in3] ^ c2 ^ c3;
  end

  always @(posedge clk) begin
    p1[0] <= c1;
    p2[0] <= c2;
    p3[0] <= c3;
    for (int i = 1; i < LAT; i++) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
      p3[i] <= p3[i-1];
    end
  end

  assign sbox_out1 = p1[LAT-1];
  assign sbox_out2 = p2[LAT-1];
  assign sbox_out3 = p3[LAT-1];

  logic [46:0] g_rnd  [16];
  logic [5:0]  g_kout [22];
  logic [3:0]  g_in1  [22];
  logic [3:0]  g_in2  [22];
  logic [3:0]  g_in3  [22];
  logic [42:0] g_r    [22];
  logic [3:0]  g_k1   [22];
  logic [5:0]  g_k2   [22];
  int          g_done_edge, g_done_cnt, g_done_abs;
  bit          g_busy_bad, g_chg;
  logic [63:0] ref1, ref2, ref3, ref_plain;
  logic [63:0] KNOWN = 64'h0123456789ABCDEF;
  logic [63:0] EXPK  = 64'hB732FD89A6405EC1;

  function automatic void build_ref(input logic [63:0] a, b, c);
    logic [3:0] x, n2, n3, e2, e3;
    for (int k = 0; k < 16; k++) begin
      x  = a[4*k +: 4] ^ b[4*k +: 4] ^ c[4*k +: 4];
      n2 = b[4*k +: 4];
      n3 = c[4*k +: 4];
      e2 = {n2[2:0], n2[3]} ^ g_rnd[k][3:0];
      e3 = n3 ^ g_rnd[k][46:43];
      ref2[4*k +: 4]      = e2;
      ref3[4*k +: 4]      = e3;
      ref1[4*k +: 4]      = SINV[x] ^ e2 ^ e3;
      ref_plain[4*k +: 4] = SINV[x];
    end
  endfunction

  task automatic run_op(input logic [63:0] a, b, c, input bit hold);
    logic [63:0] o1, o2, o3;
    o1 = state_out1;
    o2 = state_out2;
    o3 = state_out3;
    g_chg = 0;
    g_busy_bad = 0;
    g_done_cnt = 0;
    g_done_edge = -1;
    g_done_abs = -1;
    @(negedge clk);
    state_in1 = a;
    state_in2 = b;
    state_in3 = c;
    start_i = 1'b1;
    rnd_i = {15'($urandom()), $urandom()};
    sbox_klmn_out_i = 6'($urandom());
    g_rnd[0] = rnd_i;
    g_kout[0] = sbox_klmn_out_i;
    @(posedge clk);
    #1;
    g_in1[0] = sbox_in1;
    g_in2[0] = sbox_in2;
    g_in3[0] = sbox_in3;
    g_r[0]   = sbox_r_o;
    g_k1[0]  = sbox_klmn1_o;
    g_k2[0]  = sbox_klmn2_o;
    if (!busy_o) g_busy_bad = 1;
    if (!hold) start_i = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      @(negedge clk);
      state_in1 = {$urandom(), $urandom()};
      rnd_i = {15'($urandom()), $urandom()};
      sbox_klmn_out_i = 6'($urandom());
      if (e < 16) g_rnd[e] = rnd_i;
      g_kout[e] = sbox_klmn_out_i;
      @(posedge clk);
      #1;
      g_in1[e] = sbox_in1;
      g_in2[e] = sbox_in2;
      g_in3[e] = sbox_in3;
      g_r[e]   = sbox_r_o;
      g_k1[e]  = sbox_klmn1_o;
      g_k2[e]  = sbox_klmn2_o;
      if (done_o) begin
        g_done_cnt++;
        if (g_done_edge < 0) begin
          g_done_edge = e;
          g_done_abs = edge_no;
        end
      end
      if (e <= 20 && !busy_o) g_busy_bad = 1;
      if (g_done_edge < 0 &&
          {state_out1, state_out2, state_out3} !== {o1, o2, o3})
        g_chg = 1;
    end
    state_in1 = a;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o} !== 2'b00)
      $display("FAIL reset_flags got %b exp 00", {busy_o, done_o});
    checks++;
    if ({sbox_in1, sbox_in2, sbox_in3, sbox_r_o,
         sbox_klmn1_o, sbox_klmn2_o} !== '0) begin
      errors++;
      $display("FAIL reset_sbox got %h %h %h %h exp 0",
               sbox_in1, sbox_in2, sbox_in3, sbox_r_o);
    end
    checks++;
    if ({state_out1, state_out2, state_out3} !== '0) begin
      errors++;
      $display("FAIL reset_out got %h %h %h exp 0",
               state_out1, state_out2, state_out3);
    end
    if ({busy_o, done_o} !== 2'b00) errors++;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_known;
    logic [63:0] z;
    logic [63:0] x;
    z = '0;
    run_op(KNOWN, z, z, 1'b0);
    build_ref(KNOWN, z, z);
    x = state_out1 ^ state_out2 ^ state_out3;
    checks++;
    if (g_done_edge !== 20) begin
      errors++;
      $display("FAIL known_latency got %0d exp 20", g_done_edge);
    end
    checks++;
    if (g_done_cnt !== 1) begin
      errors++;
      $display("FAIL known_done_cnt got %0d exp 1", g_done_cnt);
    end
    checks++;
    if (x !== EXPK) begin
      errors++;
      $display("FAIL known_xor got %h exp %h", x, EXPK);
    end
    checks++;
    if ({state_out1, state_out2, state_out3} !== {ref1, ref2, ref3}) begin
      errors++;
      $display("FAIL known_shares got %h %h %h exp %h %h %h",
               state_out1, state_out2, state_out3, ref1, ref2, ref3);
    end
    checks++;
    if (g_busy_bad) begin
      errors++;
      $display("FAIL known_busy got 0 exp 1");
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({g_in1[k], g_in2[k], g_in3[k]} !== {KNOWN[4*k +: 4], 8'h00}) begin
        errors++;
        $display("FAIL feed_nibble%0d got %h%h%h exp %h00", k,
                 g_in1[k], g_in2[k], g_in3[k], KNOWN[4*k +: 4]);
      end
      checks++;
      if ({g_r[k], g_k1[k], g_k2[k]} !==
          {g_rnd[k][42:0], g_rnd[k][46:43], g_kout[k]}) begin
        errors++;
        $display("FAIL feed_rnd%0d got %h %h %h exp %h %h %h", k,
                 g_r[k], g_k1[k], g_k2[k],
                 g_rnd[k][42:0], g_rnd[k][46:43], g_kout[k]);
      end
    end
  endtask

  task automatic test_masked;
    logic [63:0] s1, s2, s3, x;
    for (int s = 0; s < 20; s++) begin
      s2 = {$urandom(), $urandom()};
      s3 = {$urandom(), $urandom()};
      s1 = KNOWN ^ s2 ^ s3;
      run_op(s1, s2, s3, 1'b0);
      build_ref(s1, s2, s3);
      x = state_out1 ^ state_out2 ^ state_out3;
      checks++;
      if (x !== EXPK || g_done_edge !== 20) begin
        errors++;
        $display("FAIL masked%0d_xor got %h @%0d exp %h @20",
                 s, x, g_done_edge, EXPK);
      end
      checks++;
      if ({state_out1, state_out2, state_out3} !== {ref1, ref2, ref3}) begin
        errors++;
        $display("FAIL masked%0d_shares got %h %h %h exp %h %h %h", s,
                 state_out1, state_out2, state_out3, ref1, ref2, ref3);
      end
    end
  endtask

  task automatic test_random_plain;
    logic [63:0] a, b, c, x;
    for (int s = 0; s < 5; s++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      c = {$urandom(), $urandom()};
      run_op(a, b, c, 1'b0);
      build_ref(a, b, c);
      x = state_out1 ^ state_out2 ^ state_out3;
      checks++;
      if (x !== ref_plain) begin
        errors++;
        $display("FAIL plain%0d got %h exp %h", s, x, ref_plain);
      end
    end
  endtask

  task automatic test_hold_start;
    logic [63:0] a;
    int cnt, first;
    a = {$urandom(), $urandom()};
    run_op(a, ~a, a, 1'b1);
    checks++;
    if (g_done_cnt !== 1 || g_done_edge !== 20) begin
      errors++;
      $display("FAIL hold_done got %0d @%0d exp 1 @20",
               g_done_cnt, g_done_edge);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_restart got %b exp 1", busy_o);
    end
    start_i = 1'b0;
    cnt = 0;
    first = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    checks++;
    if (cnt !== 1 || first !== 20) begin
      errors++;
      $display("FAIL hold_second got %0d @%0d exp 1 @20", cnt, first);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    int d1;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    run_op(a, b, a ^ b, 1'b0);
    build_ref(a, b, a ^ b);
    d1 = g_done_abs;
    checks++;
    if ({state_out1, state_out2, state_out3} !== {ref1, ref2, ref3}) begin
      errors++;
      $display("FAIL b2b_first got %h %h %h exp %h %h %h",
               state_out1, state_out2, state_out3, ref1, ref2, ref3);
    end
    run_op(b, a, ~a, 1'b0);
    build_ref(b, a, ~a);
    checks++;
    if (g_done_abs - d1 !== 22) begin
      errors++;
      $display("FAIL b2b_gap got %0d exp 22", g_done_abs - d1);
    end
    checks++;
    if (g_chg) begin
      errors++;
      $display("FAIL b2b_hold got changed exp stable");
    end
    checks++;
    if ({state_out1, state_out2, state_out3} !== {ref1, ref2, ref3}) begin
      errors++;
      $display("FAIL b2b_second got %h %h %h exp %h %h %h",
               state_out1, state_out2, state_out3, ref1, ref2, ref3);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] a;
    int cnt;
    a = {$urandom(), $urandom()};
    @(negedge clk);
    state_in1 = a;
    state_in2 = ~a;
    state_in3 = a ^ 64'h5555;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, sbox_in1, sbox_in2, sbox_in3, sbox_r_o,
         sbox_klmn1_o, sbox_klmn2_o} !== '0) begin
      errors++;
      $display("FAIL midreset_io got %b %h %h %h %h exp 0", busy_o,
               sbox_in1, sbox_in2, sbox_in3, sbox_r_o);
    end
    checks++;
    if ({state_out1, state_out2, state_out3} !== '0) begin
      errors++;
      $display("FAIL midreset_out got %h %h %h exp 0",
               state_out1, state_out2, state_out3);
    end
    @(negedge clk);
    rst_i = 1'b1;
    cnt = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (done_o) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL midreset_nodone got %0d exp 0", cnt);
    end
    run_op(a, ~a, a ^ 64'h5555, 1'b0);
    build_ref(a, ~a, a ^ 64'h5555);
    checks++;
    if ({state_out1, state_out2, state_out3} !== {ref1, ref2, ref3} ||
        g_done_edge !== 20) begin
      errors++;
      $display("FAIL midreset_fresh got %h @%0d exp %h @20",
               state_out1, g_done_edge, ref1);
    end
  endtask

  task automatic test_idle_outputs;
    logic [63:0] a, b, c;
    logic [54:0] exp_v;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    run_op(a, b, c, 1'b0);
    for (int e = 16; e <= 21; e++) begin
`ifdef PRINCE_SEQ_ZERO_IDLE_EN
      exp_v = '0;
`else
      exp_v = {a[63:60], b[63:60], c[63:60], g_rnd[15][42:0]};
`endif
      checks++;
      if ({g_in1[e], g_in2[e], g_in3[e], g_r[e]} !== exp_v) begin
        errors++;
        $display("FAIL idle_out%0d got %h exp %h", e,
                 {g_in1[e], g_in2[e], g_in3[e], g_r[e]}, exp_v);
      end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    state_in1 = '0;
    state_in2 = '0;
    state_in3 = '0;
    rnd_i = '0;
    sbox_klmn_out_i = '0;
    test_reset;
    test_known;
    test_masked;
    test_random_plain;
    test_hold_start;
    test_back_to_back;
    test_reset_mid;
    test_idle_outputs;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
